// File: rtl/uart_tx_sequencer_if.sv
// Baud selection type plus the bus/tick-generator/line bundle of the UART transmit sequencer.
// The slave modport is the sequencer side; master is the register/bench side.
package uart_tx_sequencer_pkg;
    typedef enum logic [2:0] {
        BAUD_SET_9600,
        BAUD_SET_19200,
        BAUD_SET_38400,
        BAUD_SET_57600,
        BAUD_SET_115200,
        BAUD_SET_230400,
        BAUD_SET_460800,
        BAUD_SET_1000000
    } baud_set_t;
endpackage

interface uart_tx_sequencer_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = 8
);
    import uart_tx_sequencer_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    baud_set_t              cfg_baud;
    logic                   cfg_parity_en;
    logic                   cfg_parity_odd;
    logic                   cfg_two_stop;
    logic                   s_valid;
    logic [DATA_BITS-1:0]   s_data;
    logic                   s_ready;
    logic                   baud_tick;
    baud_set_t              gen_baud_setting;
    logic                   gen_tx_en;
    logic                   gen_tx_done;
    logic                   txd;
    logic                   busy;
    logic [LVL_W-1:0]       fifo_level;

    modport master (
        output cfg_baud, cfg_parity_en, cfg_parity_odd, cfg_two_stop,
        output s_valid, s_data, baud_tick,
        input  s_ready, gen_baud_setting, gen_tx_en, gen_tx_done, txd, busy, fifo_level
    );

    modport slave (
        input  cfg_baud, cfg_parity_en, cfg_parity_odd, cfg_two_stop,
        input  s_valid, s_data, baud_tick,
        output s_ready, gen_baud_setting, gen_tx_en, gen_tx_done, txd, busy, fifo_level
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: byte FIFO feeding a start/data/parity/stop frame shifter,
// with enable/disable pulses and baud selection for the external tick generator.
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_16mhz,
    input  logic                 rstn,
    uart_tx_sequencer_if.slave   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
    logic                 parityBit_q, parityBit_d;
    logic                 parityEn_q, parityEn_d;
    logic                 twoStop_q, twoStop_d;
    logic                 stopCnt_q, stopCnt_d;
    logic                 txd_q, txd_d;
    logic                 txEn_q, txEn_d;
    baud_set_t            baud_q, baud_d;

    logic                 push;
    logic                 pop;
    logic                 fifoEmpty;
    logic                 lastStop;
    logic                 txDone;
    logic [DATA_BITS-1:0] headData;

    assign fifoEmpty = (level_q == '0);
    assign bus.s_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push = bus.s_valid && bus.s_ready;
    assign headData = fifoMem_q[rdPtr_q];
    assign lastStop = !twoStop_q || stopCnt_q;

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        shift_d     = shift_q;
        bitIdx_d    = bitIdx_q;
        parityBit_d = parityBit_q;
        parityEn_d  = parityEn_q;
        twoStop_d   = twoStop_q;
        stopCnt_d   = stopCnt_q;
        baud_d      = baud_q;
        txEn_d      = 1'b0;
        txd_d       = 1'b1;
        pop         = 1'b0;
        txDone      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    baud_d  = bus.cfg_baud;
                    txEn_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bus.baud_tick) begin
                    shift_d  = shift_q >> 1;
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = parityEn_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bus.baud_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bus.baud_tick) begin
                    if (!lastStop) begin
                        stopCnt_d = 1'b1;
                    end else if (!fifoEmpty) begin
                        // Back-to-back frame: generator keeps running, so no enable/disable pulse.
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        txDone  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != STOP) begin
            stopCnt_d = 1'b0;
        end

        if (pop) begin
            shift_d     = headData;
            parityBit_d = (^headData) ^ bus.cfg_parity_odd;
            parityEn_d  = bus.cfg_parity_en;
            twoStop_d   = bus.cfg_two_stop;
            rdPtr_d     = rdPtr_q + 1'b1;
        end
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        // The line register reflects the state being entered, so it changes with the state.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = parityBit_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_16mhz or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            shift_q     <= '0;
            bitIdx_q    <= '0;
            parityBit_q <= 1'b0;
            parityEn_q  <= 1'b0;
            twoStop_q   <= 1'b0;
            stopCnt_q   <= 1'b0;
            txd_q       <= 1'b1;
            txEn_q      <= 1'b0;
            baud_q      <= BAUD_SET_9600;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            shift_q     <= shift_d;
            bitIdx_q    <= bitIdx_d;
            parityBit_q <= parityBit_d;
            parityEn_q  <= parityEn_d;
            twoStop_q   <= twoStop_d;
            stopCnt_q   <= stopCnt_d;
            txd_q       <= txd_d;
            txEn_q      <= txEn_d;
            baud_q      <= baud_d;
        end
    end

    // Storage needs no reset; the pointers and level define which entries are live.
    always_ff @(posedge clk_16mhz) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= bus.s_data;
        end
    end

    assign bus.txd              = txd_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.gen_tx_en        = txEn_q;
    assign bus.gen_tx_done      = txDone;
    assign bus.gen_baud_setting = baud_q;
    assign bus.fifo_level       = level_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: table of single-frame vectors plus hand-written
// sequences for FIFO back-pressure, back-to-back frames, baud relatch and mid-frame reset.
module tb_uart_tx_sequencer;
    import uart_tx_sequencer_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int DATA_BITS  = 8;
    localparam int TICK_GAP   = 16;

    logic clk_16mhz = 1'b0;
    logic rstn      = 1'b0;

    int totalChecks = 0;
    int badChecks   = 0;
    int enCount     = 0;
    int doneCount   = 0;
    int bothCount   = 0;

    uart_tx_sequencer_if #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_BITS(DATA_BITS)) bus ();

    uart_tx_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_BITS(DATA_BITS)) dut (
        .clk_16mhz (clk_16mhz),
        .rstn      (rstn),
        .bus       (bus)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    always @(posedge clk_16mhz) begin
        if (bus.gen_tx_en)                   enCount++;
        if (bus.gen_tx_done)                 doneCount++;
        if (bus.gen_tx_en && bus.gen_tx_done) bothCount++;
    end

    typedef struct {
        logic [7:0]  data;
        logic        parEn;
        logic        parOdd;
        logic        twoStop;
        baud_set_t   baud;
        logic [11:0] expBits;
        int          nBits;
    } vector_t;

    vector_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        bus.s_valid = 1'b1;
        bus.s_data  = data;
        @(negedge clk_16mhz);
        bus.s_valid = 1'b0;
    endtask

    task automatic doTicks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (TICK_GAP - 1) @(negedge clk_16mhz);
            bus.baud_tick = 1'b1;
            @(negedge clk_16mhz);
            bus.baud_tick = 1'b0;
        end
    endtask

    // seq is MSB-first: bit 19 is the first line value of the run.
    task automatic checkTicks(input string name, input logic [19:0] seq, input int n, input logic doneLast);
        for (int i = 0; i < n; i++) begin
            repeat (TICK_GAP - 1) @(negedge clk_16mhz);
            checkOutput($sformatf("%s txd bit%0d", name, i), {31'b0, bus.txd}, {31'b0, seq[19-i]});
            bus.baud_tick = 1'b1;
            #1;
            checkOutput($sformatf("%s done tick%0d", name, i), {31'b0, bus.gen_tx_done},
                        {31'b0, (i == n - 1) ? doneLast : 1'b0});
            @(negedge clk_16mhz);
            bus.baud_tick = 1'b0;
        end
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " txd"},      {31'b0, bus.txd},         32'd1);
        checkOutput({name, " busy"},     {31'b0, bus.busy},        32'd0);
        checkOutput({name, " level"},    {29'b0, bus.fifo_level},  32'd0);
        checkOutput({name, " s_ready"},  {31'b0, bus.s_ready},     32'd1);
        checkOutput({name, " tx_en"},    {31'b0, bus.gen_tx_en},   32'd0);
        checkOutput({name, " tx_done"},  {31'b0, bus.gen_tx_done}, 32'd0);
        checkOutput({name, " baud"},     {29'b0, bus.gen_baud_setting}, {29'b0, BAUD_SET_9600});
    endtask

    initial begin
        int e0;
        int d0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, BAUD_SET_9600,    12'b010100101100, 10};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, BAUD_SET_115200,  12'b011100000110, 11};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, BAUD_SET_19200,   12'b011100000010, 11};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, BAUD_SET_9600,    12'b011100000111, 12};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, BAUD_SET_1000000, 12'b000111100110, 11};

        bus.cfg_baud       = BAUD_SET_9600;
        bus.cfg_parity_en  = 1'b0;
        bus.cfg_parity_odd = 1'b0;
        bus.cfg_two_stop   = 1'b0;
        bus.s_valid        = 1'b0;
        bus.s_data         = '0;
        bus.baud_tick      = 1'b0;

        repeat (3) @(negedge clk_16mhz);
        checkResetState("por");
        rstn = 1'b1;
        @(negedge clk_16mhz);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d data=0x%0h", v, vecs[v].data);
            bus.cfg_baud       = vecs[v].baud;
            bus.cfg_parity_en  = vecs[v].parEn;
            bus.cfg_parity_odd = vecs[v].parOdd;
            bus.cfg_two_stop   = vecs[v].twoStop;
            e0 = enCount;
            d0 = doneCount;
            applyStimulus(vecs[v].data);
            @(negedge clk_16mhz);
            checkOutput($sformatf("v%0d baud", v), {29'b0, bus.gen_baud_setting}, {29'b0, vecs[v].baud});
            checkOutput($sformatf("v%0d tx_en", v), {31'b0, bus.gen_tx_en}, 32'd1);
            checkOutput($sformatf("v%0d busy", v), {31'b0, bus.busy}, 32'd1);
            checkTicks($sformatf("v%0d", v), {vecs[v].expBits, 8'b0}, vecs[v].nBits, 1'b1);
            checkOutput($sformatf("v%0d busy after", v), {31'b0, bus.busy}, 32'd0);
            checkOutput($sformatf("v%0d txd idle", v), {31'b0, bus.txd}, 32'd1);
            checkOutput($sformatf("v%0d en pulses", v), enCount - e0, 32'd1);
            checkOutput($sformatf("v%0d done pulses", v), doneCount - d0, 32'd1);
        end

        // Two queued bytes go out with no idle gap and a single enable/disable pair.
        bus.cfg_baud      = BAUD_SET_9600;
        bus.cfg_parity_en = 1'b0;
        bus.cfg_two_stop  = 1'b0;
        e0 = enCount;
        d0 = doneCount;
        applyStimulus(8'h81);
        applyStimulus(8'h42);
        checkTicks("b2b1", {10'b0100000011, 10'b0}, 10, 1'b0);
        checkOutput("b2b gap txd", {31'b0, bus.txd}, 32'd0);
        checkOutput("b2b gap busy", {31'b0, bus.busy}, 32'd1);
        checkTicks("b2b2", {10'b0010000101, 10'b0}, 10, 1'b1);
        checkOutput("b2b busy after", {31'b0, bus.busy}, 32'd0);
        checkOutput("b2b en pulses", enCount - e0, 32'd1);
        checkOutput("b2b done pulses", doneCount - d0, 32'd1);

        // Baud selection only moves on an IDLE->START transition.
        bus.cfg_baud = BAUD_SET_9600;
        applyStimulus(8'h55);
        @(negedge clk_16mhz);
        checkOutput("baud first", {29'b0, bus.gen_baud_setting}, {29'b0, BAUD_SET_9600});
        doTicks(3);
        bus.cfg_baud = BAUD_SET_1000000;
        doTicks(1);
        checkOutput("baud mid", {29'b0, bus.gen_baud_setting}, {29'b0, BAUD_SET_9600});
        doTicks(6);
        checkOutput("baud end busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("baud end", {29'b0, bus.gen_baud_setting}, {29'b0, BAUD_SET_9600});
        applyStimulus(8'h12);
        @(negedge clk_16mhz);
        checkOutput("baud relatch", {29'b0, bus.gen_baud_setting}, {29'b0, BAUD_SET_1000000});
        doTicks(10);

        // Fill the FIFO with ticks held low, then hold the sixth byte until a pop frees room.
        bus.cfg_baud = BAUD_SET_460800;
        for (int b = 0; b < 5; b++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hF0 + 8'(b);
            @(negedge clk_16mhz);
        end
        bus.s_data = 8'hF5;
        checkOutput("full level", {29'b0, bus.fifo_level}, 32'd4);
        checkOutput("full s_ready", {31'b0, bus.s_ready}, 32'd0);
        repeat (3) @(negedge clk_16mhz);
        checkOutput("full hold level", {29'b0, bus.fifo_level}, 32'd4);
        doTicks(10);
        checkOutput("after pop level", {29'b0, bus.fifo_level}, 32'd3);
        checkOutput("after pop s_ready", {31'b0, bus.s_ready}, 32'd1);
        checkOutput("after pop busy", {31'b0, bus.busy}, 32'd1);
        @(negedge clk_16mhz);
        bus.s_valid = 1'b0;
        checkOutput("6th accepted level", {29'b0, bus.fifo_level}, 32'd4);
        checkOutput("6th s_ready", {31'b0, bus.s_ready}, 32'd0);

        // Mid-frame reset with bytes queued; outputs must drop without a clock edge.
        doTicks(3);
        #2;
        rstn = 1'b0;
        #1;
        checkResetState("async");
        @(negedge clk_16mhz);
        rstn = 1'b1;
        e0 = enCount;
        doTicks(3);
        checkOutput("post rst busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("post rst txd", {31'b0, bus.txd}, 32'd1);
        checkOutput("post rst level", {29'b0, bus.fifo_level}, 32'd0);
        checkOutput("post rst en", enCount - e0, 32'd0);
        checkOutput("en/done overlap", bothCount, 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Frame-level transmit controller for the UART peripheral. It buffers outgoing bytes in a small FIFO and sequences the baud tick generator (start/stop enable, baud selection). It shifts out start, data (LSB first), optional parity and 1 or 2 stop bits, one bit per baud_tick. It sits between the bus-side register interface and the tick generator / TX pin.

Parameters:
FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2
DATA_BITS, 8, data bits per frame

Ports:
clk_16mhz  in  1  system clock, 16 MHz
rstn  in  1  reset, asynchronous, active-low
cfg_baud  in  baud_set_t  requested baud setting
cfg_parity_en  in  1  1 = parity bit present
cfg_parity_odd  in  1  1 = odd parity, 0 = even parity
cfg_two_stop  in  1  1 = two stop bits
s_valid  in  1  write byte valid
s_data  in  DATA_BITS  write byte
s_ready  out  1  FIFO can accept a byte
baud_tick  in  1  one-cycle bit-period tick from the tick generator
gen_baud_setting  out  baud_set_t  baud selection driven to the tick generator
gen_tx_en  out  1  one-cycle pulse that enables the tick generator
gen_tx_done  out  1  one-cycle pulse that disables the tick generator
txd  out  1  serial output, idle high
busy  out  1  frame in progress
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, while rstn=0): state IDLE, FIFO empty, fifo_level=0, s_ready=1, txd=1, busy=0, gen_tx_en=0, gen_tx_done=0, gen_baud_setting=BAUD_SET_9600.
- FIFO: a push occurs when s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH), derived from registered state. Simultaneous push and pop leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH. No push is possible when full, so data is never lost or overwritten.
- State register: IDLE, START, DATA, PARITY, STOP. busy = (state != IDLE). txd is registered and takes the value below for the state being entered.
- IDLE: txd=1; baud_tick is ignored. If the FIFO is non-empty, the block does all of the following in one cycle:
  - pops the head into the shift register
  - latches cfg_parity_en, cfg_parity_odd and cfg_two_stop
  - computes the parity bit = XOR(data) ^ cfg_parity_odd
  - registers gen_baud_setting <= cfg_baud
  - asserts gen_tx_en for exactly one cycle
  - moves to START
- START: txd=0. On baud_tick, move to DATA with bit_idx=0.
- DATA: txd = shift[0]. On each baud_tick, shift right and increment bit_idx. On the tick with bit_idx == DATA_BITS-1, move to PARITY if parity is enabled, otherwise to STOP.
- PARITY: txd = parity bit. On baud_tick, move to STOP.
- STOP: txd=1; stop_cnt starts at 0. On baud_tick with two_stop=1 and stop_cnt=0, increment stop_cnt and stay in STOP. On the final stop tick:
  - FIFO non-empty (back-to-back): pop the next byte, relatch parity/stop config (baud is NOT relatched; the generator keeps running), go to START. No gen_tx_en and no gen_tx_done are issued.
  - FIFO empty: gen_tx_done=1 combinationally in that same cycle (Mealy output: STOP && last stop && baud_tick && empty), go to IDLE. The generator therefore clears its counter and disables on the same edge, leaving no residual count.
- gen_tx_en and gen_tx_done are never asserted in the same cycle.
- gen_baud_setting changes only on an IDLE->START transition. cfg_* changes mid-frame have no effect on the current frame.
- A push in the same cycle that IDLE pops an empty FIFO is not seen by that pop; the byte is sent as the next frame.
- Reset mid-frame: all outputs immediately return to their reset values, queued bytes are discarded, and the frame is truncated with the line high.

Test Plan:
- Single byte 0xA5, parity off, 1 stop, baud_tick every 16 cycles: txd = 0,1,0,1,0,0,1,0,1,1 (one value per tick). One gen_tx_en pulse; one gen_tx_done pulse coincident with the 10th tick; busy=0 the cycle after.
- 0x07 with even parity: parity bit=1. With odd parity: parity bit=0. With cfg_two_stop=1: 12 ticks per frame, txd high for the last 2.
- baud_tick held low, 6 consecutive s_valid bytes: 1 popped into the shift register, fifo_level=4, s_ready=0 while the 6th is presented; the 6th is accepted only after the next pop.
- Two bytes queued, parity off: exactly one gen_tx_en and one gen_tx_done across 20 ticks; the 2nd start bit follows the 1st stop bit with no idle gap.
- cfg_baud changed from BAUD_SET_9600 to BAUD_SET_1000000 during DATA: gen_baud_setting stays BAUD_SET_9600 until the next IDLE->START, then becomes BAUD_SET_1000000.
- rstn pulsed low during DATA with 2 bytes queued: txd=1, busy=0, fifo_level=0, gen_tx_en=gen_tx_done=0 asynchronously; after release, no frame starts without a new push.
